// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: FSM states and the
// special byte values of the set-2 keyboard protocol.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_E1
    } ps2_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    // Keyboard acknowledge/self-test/echo/resend bytes carry no key information.
    function automatic logic is_ack(input logic [7:0] b);
        return (b == BYTE_FA) || (b == BYTE_AA) || (b == BYTE_EE) || (b == BYTE_FE);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 byte stream into make/break/repeat key events and tracks the
// currently held key; malformed or stalled sequences pulse protocol_error.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int E1_SKIP_BYTES  = 7
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_break,
    output logic       key_repeat,
    output logic       key_valid,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic       held_valid,
    output logic       protocol_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int SW = $clog2(E1_SKIP_BYTES) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SKIP_LAST    = SW'(E1_SKIP_BYTES - 1);

    ps2_state_t    state_reg, state_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [SW-1:0] skip_reg, skip_next;
    logic          ev_fire, ev_ext, ev_brk, err_next, held_match;

    always_comb begin
        state_next = state_reg;
        tmo_next   = tmo_reg;
        skip_next  = skip_reg;
        ev_fire    = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        err_next   = 1'b0;
        if (received_data_en) begin
            // Any strobe restarts the idle timer, so a byte always beats expiry.
            tmo_next = '0;
            if (is_ack(received_data)) begin
                state_next = state_reg;
            end else if (received_data == BYTE_00 || received_data == BYTE_FF) begin
                err_next   = 1'b1;
                state_next = IDLE;
                skip_next  = '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (received_data == BYTE_E0) begin
                            state_next = GOT_E0;
                        end else if (received_data == BYTE_F0) begin
                            state_next = GOT_F0;
                        end else if (received_data == BYTE_E1) begin
                            state_next = SKIP_E1;
                            skip_next  = '0;
                        end else begin
                            ev_fire = 1'b1;
                        end
                    end
                    GOT_E0: begin
                        if (received_data == BYTE_F0) begin
                            state_next = GOT_E0F0;
                        end else if (received_data != BYTE_E0) begin
                            ev_fire    = 1'b1;
                            ev_ext     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    GOT_F0, GOT_E0F0: begin
                        state_next = IDLE;
                        if (received_data == BYTE_F0) begin
                            err_next = 1'b1;
                        end else begin
                            ev_fire = 1'b1;
                            ev_brk  = 1'b1;
                            ev_ext  = (state_reg == GOT_E0F0);
                        end
                    end
                    SKIP_E1: begin
                        if (skip_reg == SKIP_LAST) begin
                            state_next = IDLE;
                            skip_next  = '0;
                        end else begin
                            skip_next = skip_reg + SW'(1);
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end else if (state_reg != IDLE) begin
            if (tmo_reg == TIMEOUT_LAST) begin
                err_next   = 1'b1;
                state_next = IDLE;
                tmo_next   = '0;
                skip_next  = '0;
            end else begin
                tmo_next = tmo_reg + TW'(1);
            end
        end
    end

    assign held_match = held_valid && (held_code == received_data) && (held_ext == ev_ext);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            tmo_reg        <= '0;
            skip_reg       <= '0;
            key_code       <= '0;
            key_extended   <= 1'b0;
            key_break      <= 1'b0;
            key_repeat     <= 1'b0;
            key_valid      <= 1'b0;
            held_code      <= '0;
            held_ext       <= 1'b0;
            held_valid     <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tmo_reg        <= tmo_next;
            skip_reg       <= skip_next;
            key_valid      <= ev_fire;
            protocol_error <= err_next;
            if (ev_fire) begin
                key_code     <= received_data;
                key_extended <= ev_ext;
                key_break    <= ev_brk;
                key_repeat   <= !ev_brk && held_match;
                if (!ev_brk) begin
                    held_code  <= received_data;
                    held_ext   <= ev_ext;
                    held_valid <= 1'b1;
                end else if (held_match) begin
                    held_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the idle cycles allowed inside a multi-byte sequence (20 ms at 50 MHz).
REQ-002 SHALL have parameter E1_SKIP_BYTES, default 7, meaning the bytes discarded after an 0xE1 (Pause) prefix.
REQ-003 SHALL have port CLOCK_50  in  1  system clock; all logic runs on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port received_data  in  8  byte from the PS/2 receiver.
REQ-006 SHALL have port received_data_en  in  1  one-cycle strobe qualifying received_data.
REQ-007 SHALL have port key_code  out  8  scan code of the last decoded event.
REQ-008 SHALL have port key_extended  out  1  event was 0xE0-prefixed.
REQ-009 SHALL have port key_break  out  1  event is a release (0xF0-prefixed).
REQ-010 SHALL have port key_repeat  out  1  event is a typematic repeat of the held key.
REQ-011 SHALL have port key_valid  out  1  one-cycle pulse qualifying key_code, key_extended, key_break and key_repeat.
REQ-012 SHALL have port held_code  out  8  code of the currently held key.
REQ-013 SHALL have port held_ext  out  1  extended flag of the held key.
REQ-014 SHALL have port held_valid  out  1  a key is currently held.
REQ-015 SHALL have port protocol_error  out  1  one-cycle pulse on a malformed sequence.

Function
REQ-016 SHALL use an FSM with states IDLE, GOT_E0, GOT_F0, GOT_E0F0 and SKIP_E1.
REQ-017 IDLE transitions: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; 0xE1 -> SKIP_E1; any other accepted code -> make event, stay in IDLE.
REQ-018 GOT_E0 transitions: 0xF0 -> GOT_E0F0; 0xE0 -> stay in GOT_E0; other -> extended make event, then IDLE.
REQ-019 GOT_F0 transitions: any accepted code -> break event, then IDLE.
REQ-020 GOT_E0F0 transitions: any accepted code -> extended break event, then IDLE.
REQ-021 SKIP_E1: SHALL count and discard E1_SKIP_BYTES strobes, emit no event, then return to IDLE.
REQ-022 Bytes 0xFA, 0xAA, 0xEE and 0xFE in any state SHALL be dropped silently with no state change.
REQ-023 Bytes 0x00 and 0xFF (overflow) in any state SHALL pulse protocol_error and force IDLE.
REQ-024 0xF0 received in GOT_F0 or GOT_E0F0 SHALL pulse protocol_error and force IDLE.
REQ-025 Latency: key_valid and its qualifiers SHALL be registered and asserted the cycle after the received_data_en of the final byte.
REQ-026 Between events, key_code, key_extended, key_break and key_repeat SHALL hold their last values.
REQ-027 Make events SHALL load held_code and held_ext and set held_valid.
REQ-028 A make with code and ext matching a held key SHALL set key_repeat=1; all other events SHALL set key_repeat=0.
REQ-029 A break matching the held key SHALL clear held_valid; a non-matching break SHALL leave the held state unchanged.
REQ-030 Timeout: a counter SHALL run in any non-IDLE state and clear on each strobe.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse protocol_error and force IDLE.
REQ-032 If a strobe and timeout expiry coincide, the byte SHALL win: it is decoded normally and no error is raised.
REQ-033 The timeout counter SHALL saturate and never wrap.

Reset
REQ-034 resetn low SHALL immediately put the FSM in IDLE.
REQ-035 resetn low SHALL immediately clear all outputs, counters and held state to 0.
REQ-036 Reset asserted mid-sequence SHALL discard the partial sequence, and the first byte after release SHALL be decoded from IDLE.

Structure
REQ-037 Package ps2_pkg SHALL hold the FSM state enum and the byte constants E0, F0, E1, FA, AA, EE, FE, 00 and FF.
REQ-038 The block SHALL be a single module with no sub-module; the timeout counter and skip counter SHALL be inline.

Verification
REQ-039 Make 0x34 -> key_valid with code 34, ext 0, break 0; held_code 34; held_valid 1.
REQ-040 Bytes E0, F0, 75 -> key_valid with code 75, ext 1, break 1; held state unchanged when 0x75 ext is not held.
REQ-041 Bytes 2D, 2D, F0, 2D -> repeat 0 then repeat 1, then break; held_valid 0 at the end.
REQ-042 Bytes E1, 14, 77, E1, F0, 14, F0, 77 -> no key_valid, then IDLE; a following 0x1D decodes as a make.
REQ-043 Byte F0, then no strobe for TIMEOUT_CYCLES (set to 16 in the bench) -> protocol_error pulse; a following 0x33 is a make, not a break.
REQ-044 Reset after E0, then 0x2A -> non-extended make 2A; a byte 0x00 at any point -> protocol_error pulse and IDLE.
